// File: rtl/coin_acceptor.sv
// Coin sensor front end: per-slot synchroniser, debouncer and pulse-width FSM,
// then a small coin FIFO drained one code at a time with an idle gap.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_PULSE       = 64,
    parameter int QDEPTH          = 4,
    parameter int GAP             = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      coin5_raw,
    input  logic                      coin10_raw,
    input  logic                      enable,
    input  logic                      jam_clr,
    output logic [1:0]                coin,
    output logic                      reject,
    output logic                      jam,
    output logic [$clog2(QDEPTH):0]   pending
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int PW_W  = $clog2(MAX_PULSE + 2);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_HIGH   = 2'd1,
        CH_JAMMED = 2'd2
    } ch_state_t;

    typedef enum logic {
        EM_IDLE = 1'b0,
        EM_GAP  = 1'b1
    } em_state_t;

    // Channel index 0 is the 5-rupee slot, index 1 the 10-rupee slot.
    logic [1:0]       raw_s;
    logic [1:0]       sync1_r;
    logic [1:0]       sync2_r;
    logic [1:0]       deb_r;
    logic [DB_W-1:0]  db_cnt_r [2];
    ch_state_t        ch_state_r [2];
    logic [PW_W-1:0]  width_r [2];
    logic [1:0]       bad_r;

    logic             both_high_s;
    logic [1:0]       fall_ev_s;
    logic [1:0]       jam_ev_s;
    logic [1:0]       rej_ev_s;
    logic [1:0]       acc_ev_s;
    logic             full_s;
    logic             enq_s;
    logic [1:0]       enq_code_s;
    logic             pop_s;
    logic [2:0]       rej_total_s;

    logic [1:0]       fifo_r [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    em_state_t        em_state_r;
    logic [GAP_W-1:0] gap_cnt_r;
    logic [2:0]       rej_backlog_r;

    assign raw_s   = {coin10_raw, coin5_raw};
    assign pending = count_r;

    // Decode channel events and resolve each completed coin into accept or reject
    always_comb begin
        both_high_s = (ch_state_r[0] == CH_HIGH) && (ch_state_r[1] == CH_HIGH);
        full_s      = (count_r == CNT_W'(QDEPTH));
        fall_ev_s   = 2'b00;
        jam_ev_s    = 2'b00;
        rej_ev_s    = 2'b00;
        acc_ev_s    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (ch_state_r[i] == CH_HIGH) begin
                if (width_r[i] > PW_W'(MAX_PULSE)) begin
                    jam_ev_s[i] = 1'b1;
                end else if (!deb_r[i]) begin
                    fall_ev_s[i] = 1'b1;
                end else begin
                    fall_ev_s[i] = 1'b0;
                end
            end else begin
                fall_ev_s[i] = 1'b0;
            end
            rej_ev_s[i] = fall_ev_s[i] && (bad_r[i] || both_high_s || !enable || full_s);
            acc_ev_s[i] = fall_ev_s[i] && !(bad_r[i] || both_high_s || !enable || full_s);
        end
        // Two clean falls in one cycle cannot happen: both channels would be HIGH together.
        enq_s       = |acc_ev_s;
        enq_code_s  = acc_ev_s[0] ? 2'b01 : 2'b10;
        pop_s       = (em_state_r == EM_IDLE) && (count_r != CNT_W'(0));
        rej_total_s = rej_backlog_r + {2'b00, rej_ev_s[0]} + {2'b00, rej_ev_s[1]};
    end

    // Synchronisers, debouncers and per-channel pulse FSMs
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
            deb_r   <= 2'b00;
            bad_r   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt_r[i]   <= '0;
                ch_state_r[i] <= CH_IDLE;
                width_r[i]    <= '0;
            end
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_r[i]    <= ~deb_r[i];
                    db_cnt_r[i] <= '0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + 1'b1;
                end

                case (ch_state_r[i])
                    CH_IDLE: begin
                        if (deb_r[i]) begin
                            ch_state_r[i] <= CH_HIGH;
                            width_r[i]    <= PW_W'(1);
                            bad_r[i]      <= 1'b0;
                        end else begin
                            ch_state_r[i] <= CH_IDLE;
                        end
                    end
                    CH_HIGH: begin
                        if (jam_ev_s[i]) begin
                            ch_state_r[i] <= CH_JAMMED;
                        end else if (fall_ev_s[i]) begin
                            ch_state_r[i] <= CH_IDLE;
                        end else begin
                            if (width_r[i] != PW_W'(MAX_PULSE + 1)) begin
                                width_r[i] <= width_r[i] + 1'b1;
                            end else begin
                                width_r[i] <= width_r[i];
                            end
                            if (both_high_s) begin
                                bad_r[i] <= 1'b1;
                            end else begin
                                bad_r[i] <= bad_r[i];
                            end
                        end
                    end
                    CH_JAMMED: begin
                        if (!deb_r[i]) begin
                            ch_state_r[i] <= CH_IDLE;
                        end else begin
                            ch_state_r[i] <= CH_JAMMED;
                        end
                    end
                    default: ch_state_r[i] <= CH_IDLE;
                endcase
            end
        end
    end

    // Coin FIFO, output emitter, reject serialiser and sticky jam flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            em_state_r    <= EM_IDLE;
            gap_cnt_r     <= '0;
            coin          <= 2'b00;
            reject        <= 1'b0;
            rej_backlog_r <= 3'd0;
            jam           <= 1'b0;
        end else begin
            if (enq_s) begin
                fifo_r[wr_ptr_r] <= enq_code_s;
                wr_ptr_r         <= wr_ptr_r + 1'b1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({enq_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase

            case (em_state_r)
                EM_IDLE: begin
                    if (pop_s) begin
                        coin       <= fifo_r[rd_ptr_r];
                        em_state_r <= EM_GAP;
                        gap_cnt_r  <= GAP_W'(GAP - 1);
                    end else begin
                        coin <= 2'b00;
                    end
                end
                EM_GAP: begin
                    coin <= 2'b00;
                    if (gap_cnt_r == GAP_W'(0)) begin
                        em_state_r <= EM_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 1'b1;
                    end
                end
                default: begin
                    coin       <= 2'b00;
                    em_state_r <= EM_IDLE;
                end
            endcase

            // A double-coin reject owes two pulses; the backlog spreads them over cycles.
            if (rej_total_s != 3'd0) begin
                reject        <= 1'b1;
                rej_backlog_r <= rej_total_s - 3'd1;
            end else begin
                reject        <= 1'b0;
                rej_backlog_r <= 3'd0;
            end

            if (|jam_ev_s) begin
                jam <= 1'b1;
            end else if (jam_clr) begin
                jam <= 1'b0;
            end else begin
                jam <= jam;
            end
        end
    end
endmodule
